// File: rtl/sn_pipe.sv
`default_nettype none
// ============================================================================
// sn_pipe : pipelined odd-even transposition sorter, N lanes of WIDTH bits,
//           one register stage per comparator layer, valid/ready with stall.
//           Optional lane-index tagging: define SN_PIPE_INDEX_EN.
// Rev 1.0
// ============================================================================
module sn_pipe #(
  parameter int N      = 6,
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
`ifdef SN_PIPE_INDEX_EN
  ,
  localparam int IW    = $clog2(N)
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   din,
  input  logic                 in_desc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   dout,
  output logic                 out_desc
`ifdef SN_PIPE_INDEX_EN
  ,
  output logic [N*IW-1:0]      dout_idx
`endif
);

  localparam int VW = N * WIDTH;

  logic              advance;
  logic [VW-1:0]     data_q  [N];
  logic [VW-1:0]     data_in [N];
  logic [VW-1:0]     data_d  [N];
  logic [N-1:0]      valid_q;
  logic [N-1:0]      valid_in;
  logic [N-1:0]      desc_q;
  logic [N-1:0]      desc_in;

  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign advance   = !valid_q[N-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[N-1];
  assign dout      = data_q[N-1];
  assign out_desc  = desc_q[N-1];

  // Stage k's layer reads stage k-1; stage 0's layer reads the input port.
  assign valid_in   = {valid_q[N-2:0], in_valid};
  assign desc_in    = {desc_q[N-2:0], in_desc};
  assign data_in[0] = din;
  for (genvar k = 1; k < N; k++) begin : g_link
    assign data_in[k] = data_q[k-1];
  end

`ifdef SN_PIPE_INDEX_EN
  logic [N*IW-1:0]   tag_q   [N];
  logic [N*IW-1:0]   tag_in  [N];
  logic [N*IW-1:0]   tag_d   [N];
  logic [N*IW-1:0]   tag_init;

  always_comb begin
    tag_init = '0;
    for (int i = 0; i < N; i++) tag_init[i*IW +: IW] = IW'(i);
  end

  assign tag_in[0] = tag_init;
  for (genvar k = 1; k < N; k++) begin : g_tag_link
    assign tag_in[k] = tag_q[k-1];
  end
  assign dout_idx = tag_q[N-1];
`endif

  // Pairs within a layer are disjoint, so every compare reads the layer input.
  always_comb begin
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             swap;
    for (int k = 0; k < N; k++) begin
      data_d[k] = data_in[k];
`ifdef SN_PIPE_INDEX_EN
      tag_d[k]  = tag_in[k];
`endif
      for (int p = k % 2; p + 1 < N; p += 2) begin
        lo   = data_in[k][p*WIDTH +: WIDTH];
        hi   = data_in[k][(p+1)*WIDTH +: WIDTH];
        swap = desc_in[k] ? gt(hi, lo) : gt(lo, hi);
        if (swap) begin
          data_d[k][p*WIDTH +: WIDTH]     = hi;
          data_d[k][(p+1)*WIDTH +: WIDTH] = lo;
`ifdef SN_PIPE_INDEX_EN
          tag_d[k][p*IW +: IW]            = tag_in[k][(p+1)*IW +: IW];
          tag_d[k][(p+1)*IW +: IW]        = tag_in[k][p*IW +: IW];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      desc_q  <= '0;
      for (int k = 0; k < N; k++) data_q[k] <= '0;
    end else if (advance) begin
      valid_q <= valid_in;
      desc_q  <= desc_in;
      for (int k = 0; k < N; k++) data_q[k] <= data_d[k];
    end
  end

`ifdef SN_PIPE_INDEX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) tag_q[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < N; k++) tag_q[k] <= tag_d[k];
    end
  end
`endif

endmodule
`default_nettype wire
